// File: rtl/fifo_stream_writer_pkg.sv
// Shared definitions for the FIFO stream writer: default FIFO address width and writer FSM states.
package fifo_stream_writer_pkg;

  localparam int unsigned FIFO_ADDR_W = 11;

  typedef enum logic [0:0] {
    WR_IDLE,
    WR_SEND
  } wr_state_e;

endpackage

// File: rtl/fifo_stream_writer_addr_sync.sv
// addr_stable_sync: brings the FIFO read address into the write clock domain. Two flops, then the
// output only takes a value that was seen unchanged in both stages, so a pointer caught mid-change
// is never used. A held (stale) value only under-reports free space.
module addr_stable_sync
  import fifo_stream_writer_pkg::*;
#(
  parameter int unsigned Width = FIFO_ADDR_W
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [Width-1:0] addr_i,
  output logic [Width-1:0] addr_o
);

  logic [Width-1:0] s1_q, s1_d;
  logic [Width-1:0] s2_q, s2_d;
  logic [Width-1:0] sync_q, sync_d;

  // Shift the raw address through two stages; accept it only when both stages agree.
  always_comb begin
    s1_d   = addr_i;
    s2_d   = s1_q;
    sync_d = sync_q;
    if (s1_q == s2_q) begin
      sync_d = s2_q;
    end
  end

  // Synchronizer and filtered-address registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      sync_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      sync_q <= sync_d;
    end
  end

  assign addr_o = sync_q;

endmodule

// File: rtl/fifo_stream_writer.sv
// fifo_stream_writer: takes 32-bit words on a valid/ready stream and writes their low BYTES bytes,
// MSB first, into a byte-wide FIFO. A word is only accepted when all of its bytes fit, using the
// local write pointer and a filtered copy of the FIFO read address.
// Optional build macro FIFO_STREAM_WRITER_STALL_CNT_EN adds a saturating stall counter output.
module fifo_stream_writer
  import fifo_stream_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = FIFO_ADDR_W,
  parameter int unsigned BYTES  = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        fifo_data,
  output logic              fifo_write,
  input  logic [ADDR_W-1:0] fifo_addr_in,
  input  logic [ADDR_W-1:0] fifo_addr_out,
  output logic [ADDR_W-1:0] level,
  output logic              ptr_err
`ifdef FIFO_STREAM_WRITER_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] One      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] NeedWord = ADDR_W'(BYTES);
  // At the last byte the current byte still occupies a slot, so a follow-on word needs more room.
  localparam logic [ADDR_W-1:0] NeedB2b  = ADDR_W'(2 * BYTES - 1);
  localparam logic [1:0]        LastIdx  = 2'(BYTES - 1);
  localparam int unsigned       AlignSh  = 8 * (4 - BYTES);

  wr_state_e         state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       sh_q, sh_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              chk_q, chk_d;
  logic              ptr_err_q, ptr_err_d;
  logic [ADDR_W-1:0] rd_sync;
  logic [ADDR_W-1:0] free;
  logic              last_byte;
  logic              accept;

  addr_stable_sync #(
    .Width (ADDR_W)
  ) u_rd_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .addr_i (fifo_addr_out),
    .addr_o (rd_sync)
  );

  // Space accounting and handshake; one slot is always kept empty to tell full from empty.
  always_comb begin
    free      = rd_sync - wr_ptr_q - One;
    level     = wr_ptr_q - rd_sync;
    last_byte = (state_q == WR_SEND) && (idx_q == LastIdx);
    s_ready   = (free >= NeedWord) &&
                ((state_q == WR_IDLE) || (last_byte && (free >= NeedB2b)));
    accept    = s_valid && s_ready;
  end

  // FIFO write port driven straight from the FSM state and shift register.
  always_comb begin
    fifo_write = 1'b0;
    fifo_data  = 8'h00;
    if (state_q == WR_SEND) begin
      fifo_write = 1'b1;
      fifo_data  = sh_q[31:24];
    end
  end

  // FSM next state: load on accept, shift one byte per SEND cycle, reload on back-to-back accept.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    wr_ptr_d = wr_ptr_q;
    unique case (state_q)
      WR_IDLE: begin
        if (accept) begin
          sh_d    = s_data << AlignSh;
          idx_d   = 2'd0;
          state_d = WR_SEND;
        end
      end
      WR_SEND: begin
        sh_d     = {sh_q[23:0], 8'h00};
        idx_d    = idx_q + 2'd1;
        wr_ptr_d = wr_ptr_q + One;
        if (idx_q == LastIdx) begin
          if (accept) begin
            sh_d  = s_data << AlignSh;
            idx_d = 2'd0;
          end else begin
            state_d = WR_IDLE;
          end
        end
      end
    endcase
  end

  // Pointer consistency: compare one cycle after a write, once the FIFO has bumped its address.
  always_comb begin
    chk_d     = fifo_write;
    ptr_err_d = ptr_err_q | (chk_q & (wr_ptr_q != fifo_addr_in));
  end

  // State registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= WR_IDLE;
      idx_q     <= 2'd0;
      sh_q      <= 32'h0;
      wr_ptr_q  <= '0;
      chk_q     <= 1'b0;
      ptr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      wr_ptr_q  <= wr_ptr_d;
      chk_q     <= chk_d;
      ptr_err_q <= ptr_err_d;
    end
  end

  assign ptr_err = ptr_err_q;

`ifdef FIFO_STREAM_WRITER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a word is offered but blocked, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (s_valid && !s_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      stall_cnt_q <= 16'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_writer.sv
// Directed bench for fifo_stream_writer with a behavioural byte FIFO and an independent read clock.
module tb_fifo_stream_writer;

  localparam int unsigned AW = 11;

  logic          clk_in  = 1'b0;
  logic          clk_out = 1'b0;
  logic          reset   = 1'b1;
  logic [31:0]   s_data  = 32'h0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    fifo_data;
  logic          fifo_write;
  logic [AW-1:0] fifo_addr_in;
  logic [AW-1:0] fifo_addr_out;
  logic [AW-1:0] level;
  logic          ptr_err;
`ifdef FIFO_STREAM_WRITER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  // FIFO model state
  logic [AW-1:0] fwr;
  logic [AW-1:0] rd_ptr   = '0;
  logic [AW-1:0] addr_off = '0;
  logic [7:0]    mem [2048];
  int            overflow_cnt = 0;
  bit            wrapped      = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus bookkeeping
  logic [7:0]  exp_q [$];
  logic [7:0]  exp1 [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [31:0] words [3] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
  logic [7:0]  exp2 [12] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                             8'hC0, 8'hC1, 8'hC2, 8'hC3};
  logic [7:0]  exp5 [4]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [31:0] w;
  logic [7:0]  got_b;
  logic        acc;
  int          k, nacc, nwr, waited, n_to, drained, stream_bad, guard;

  assign fifo_addr_in  = fwr + addr_off;
  assign fifo_addr_out = rd_ptr;

  always #5 clk_in = ~clk_in;
  initial begin
    #1;
    forever #7 clk_out = ~clk_out;
  end

  // Behavioural FIFO write side, reset together with the writer.
  always @(posedge clk_in) begin
    if (reset) begin
      fwr <= '0;
    end else if (fifo_write) begin
      if ((fwr + 11'd1) == rd_ptr) overflow_cnt <= overflow_cnt + 1;
      if (fwr == 11'd2047) wrapped <= 1'b1;
      mem[fwr] <= fifo_data;
      fwr      <= fwr + 11'd1;
    end
  end

  fifo_stream_writer dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .fifo_data     (fifo_data),
    .fifo_write    (fifo_write),
    .fifo_addr_in  (fifo_addr_in),
    .fifo_addr_out (fifo_addr_out),
    .level         (level),
    .ptr_err       (ptr_err)
`ifdef FIFO_STREAM_WRITER_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    s_valid  = 1'b0;
    addr_off = '0;
    rd_ptr   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded limit 500000", $time);
    $fatal(1);
  end

  initial begin
    // Reset values and single word
    do_reset();
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_write", 32'(fifo_write), 32'd0);
    check("rst_data", 32'(fifo_data), 32'h0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ptr_err", 32'(ptr_err), 32'd0);
    s_data  = 32'h11223344;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("w1_byte", 32'({fifo_write, fifo_data}), 32'({1'b1, exp1[i]}));
      tick();
    end
    check("w1_idle", 32'(fifo_write), 32'd0);
    check("w1_level", 32'(level), 32'd4);
    tick();
    tick();
    check("w1_ptr_err", 32'(ptr_err), 32'd0);

    // Back-to-back words, no bubble
    do_reset();
    k       = 0;
    s_data  = words[0];
    s_valid = 1'b1;
    acc     = s_ready;
    tick();
    if (acc) begin
      k      = 1;
      s_data = words[1];
    end
    for (int j = 0; j < 12; j++) begin
      check("b2b_byte", 32'({fifo_write, fifo_data}), 32'({1'b1, exp2[j]}));
      acc = s_valid && s_ready;
      tick();
      if (acc) begin
        k++;
        if (k < 3) s_data = words[k];
        else s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    check("b2b_end", 32'(fifo_write), 32'd0);
    check("b2b_level", 32'(level), 32'd12);

    // Fill with reader stalled, then release one byte
    do_reset();
    s_data  = 32'h5A5A5A5A;
    s_valid = 1'b1;
    nacc    = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!s_ready && !fifo_write && nacc > 0) break;
      if (s_ready) nacc++;
      tick();
    end
    check("fill_words", 32'(nacc), 32'd511);
    check("fill_level", 32'(level), 32'd2044);
    check("full_ready", 32'(s_ready), 32'd0);
    tick();
    check("full_no_write", 32'(fifo_write), 32'd0);
    rd_ptr = 11'd1;
    tick();
    check("rd_adv_t1", 32'(s_ready), 32'd0);
    tick();
    check("rd_adv_t2", 32'(s_ready), 32'd0);
    tick();
    check("rd_adv_t3", 32'(s_ready), 32'd1);
    check("rd_adv_level", 32'(level), 32'd2043);
    s_valid = 1'b0;

    // free == BYTES-1 boundary and stall counting
    do_reset();
    rd_ptr = 11'd4;
    repeat (4) tick();
    check("lim_ready", 32'(s_ready), 32'd0);
    check("lim_level", 32'(level), 32'd2044);
    s_valid = 1'b1;
    nwr     = 0;
    repeat (5) begin
      tick();
      nwr += int'(fifo_write);
    end
    s_valid = 1'b0;
    check("lim_no_write", 32'(nwr), 32'd0);
`ifdef FIFO_STREAM_WRITER_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // Long run with reader draining on clk_out; pointer wraps
    do_reset();
    drained    = 0;
    stream_bad = 0;
    n_to       = 0;
    guard      = 0;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          w       = (32'h01030507 * 32'(i + 1)) ^ 32'h5AA5C33C;
          s_data  = w;
          s_valid = 1'b1;
          waited  = 0;
          while (!s_ready && waited < 500) begin
            tick();
            waited++;
          end
          if (waited >= 500) n_to++;
          for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
          tick();
        end
        s_valid = 1'b0;
      end
      begin
        while (drained < 2400 && guard < 20000) begin
          @(posedge clk_out);
          guard++;
          if (rd_ptr != fwr) begin
            got_b = mem[rd_ptr];
            if (exp_q.size() == 0) stream_bad++;
            else if (got_b !== exp_q.pop_front()) stream_bad++;
            rd_ptr = rd_ptr + 11'd1;
            drained++;
          end
        end
      end
    join
    check("wrap_prod_timeouts", 32'(n_to), 32'd0);
    check("wrap_drained", 32'(drained), 32'd2400);
    check("wrap_stream_bad", 32'(stream_bad), 32'd0);
    check("wrap_leftover", 32'(exp_q.size()), 32'd0);
    check("wrap_overflow", 32'(overflow_cnt), 32'd0);
    check("wrap_wrapped", 32'(wrapped), 32'd1);
    repeat (4) tick();
    check("wrap_level", 32'(level), 32'd0);
    check("wrap_ptr_err", 32'(ptr_err), 32'd0);

    // Reset in the middle of a word
    do_reset();
    s_data  = 32'hCAFEF00D;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    check("mid_b1", 32'({fifo_write, fifo_data}), 32'({1'b1, 8'hCA}));
    tick();
    check("mid_b2", 32'({fifo_write, fifo_data}), 32'({1'b1, 8'hFE}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_write", 32'(fifo_write), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    nwr = 0;
    repeat (3) begin
      tick();
      nwr += int'(fifo_write);
    end
    check("mid_no_write", 32'(nwr), 32'd0);
    s_data  = 32'hDEADBEEF;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 4; i++) check("restart_mem", 32'(mem[i]), 32'(exp5[i]));
    check("restart_level", 32'(level), 32'd4);
    check("restart_ptr_err", 32'(ptr_err), 32'd0);

    // Write-address mismatch is flagged after a write and stays sticky
    addr_off = 11'd1;
    repeat (3) tick();
    check("perr_no_write", 32'(ptr_err), 32'd0);
    s_data  = 32'h01020304;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (5) tick();
    check("perr_set", 32'(ptr_err), 32'd1);
    addr_off = '0;
    repeat (5) tick();
    check("perr_sticky", 32'(ptr_err), 32'd1);
    do_reset();
    check("perr_cleared", 32'(ptr_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
